// File: rtl/color_regfile_param.sv
// color_regfile_param: per-channel RGB colour registers updated by handshaked commands and preset buttons
module color_regfile_param #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int NUM_PRESET = 8,
    parameter int PRE_W      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CH_W-1:0]           channel,
    input  logic [3:0]                address,
    input  logic [3:0]                data,
    input  logic                      valid,
    output logic                      ack,
    output logic                      err,
    input  logic                      color_next,
    input  logic                      color_prev,
    output logic [NUM_CH*24-1:0]      rgb,
    output logic [NUM_CH*PRE_W-1:0]   preset_idx
);
    typedef enum logic {IDLE, ACK} state_t;

    localparam logic [23:0] ROM [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                                        24'h00FFFF, 24'hFF00FF, 24'hFFFFFF, 24'h000000};

    function automatic logic [23:0] rom(input logic [PRE_W-1:0] k);
        logic [31:0] kk;
        kk = 32'(k);
        return ROM[kk[2:0]];
    endfunction

    state_t            state_q, state_d;
    logic              ack_q, ack_d, err_q, err_d;
    logic              nxt_hist_q, prv_hist_q;
    logic [23:0]       rgb_q [NUM_CH];
    logic [23:0]       rgb_d [NUM_CH];
    logic [PRE_W-1:0]  idx_q [NUM_CH];
    logic [PRE_W-1:0]  idx_d [NUM_CH];
    logic [PRE_W-1:0]  pre, src_idx;
    logic [CH_W-1:0]   src;
    logic [23:0]       src_rgb;
    logic              fire, legal, ch_ok, fwd, step;

    assign pre   = PRE_W'(data);
    assign src   = CH_W'(data);
    assign fire  = state_q == IDLE && valid;
    assign ch_ok = 32'(channel) < NUM_CH;
    assign legal = ch_ok && address >= 4'd3 && address <= 4'd10 &&
                   (address != 4'd9 || 32'(pre) < NUM_PRESET) &&
                   (address != 4'd10 || 32'(src) < NUM_CH);
    // both buttons rising together cancel out
    assign fwd   = color_next & ~nxt_hist_q;
    assign step  = fwd ^ (color_prev & ~prv_hist_q);

    // snapshot of the copy source as it stood before this edge
    always_comb begin
        src_rgb = '0;
        src_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (src == CH_W'(i)) begin
                src_rgb = rgb_q[i];
                src_idx = idx_q[i];
            end
        end
    end

    // command update first, then a button step on the same channel overrides it
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            rgb_d[i] = rgb_q[i];
            idx_d[i] = idx_q[i];
            if (fire && legal && channel == CH_W'(i)) begin
                if (address == 4'd9) begin
                    idx_d[i] = pre;
                    rgb_d[i] = rom(pre);
                end else if (address == 4'd10) begin
                    idx_d[i] = src_idx;
                    rgb_d[i] = src_rgb;
                end else begin
                    rgb_d[i][4*(8-int'(address)) +: 4] = data;
                end
            end
            if (step && channel == CH_W'(i)) begin
                idx_d[i] = fwd ? (idx_q[i] == PRE_W'(NUM_PRESET-1) ? '0 : idx_q[i] + 1'b1)
                               : (idx_q[i] == '0 ? PRE_W'(NUM_PRESET-1) : idx_q[i] - 1'b1);
                rgb_d[i] = rom(idx_d[i]);
            end
        end
    end

    // handshake: accept in IDLE, spend one cycle in ACK pulsing ack or err
    always_comb begin
        state_d = fire ? ACK : IDLE;
        ack_d   = fire && legal;
        err_d   = fire && !legal;
    end

    // all state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            nxt_hist_q <= 1'b0;
            prv_hist_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                idx_q[i] <= PRE_W'(i % NUM_PRESET);
                rgb_q[i] <= rom(PRE_W'(i % NUM_PRESET));
            end
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            nxt_hist_q <= color_next;
            prv_hist_q <= color_prev;
            rgb_q      <= rgb_d;
            idx_q      <= idx_d;
        end
    end

    assign ack = ack_q;
    assign err = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign rgb[24*g +: 24]              = rgb_q[g];
        assign preset_idx[PRE_W*g +: PRE_W] = idx_q[g];
    end
endmodule

// File: tb/tb_color_regfile_param.sv
// tb_color_regfile_param: directed and randomized checks of color_regfile_param against a behavioural model
module tb_color_regfile_param;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  channel;
    logic [3:0]  address, data;
    logic        valid, color_next, color_prev;
    logic        ack, err;
    logic [95:0] rgb;
    logic [11:0] preset_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] rom_m [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                               24'h00FFFF, 24'hFF00FF, 24'hFFFFFF, 24'h000000};
    logic [23:0] m_rgb [4];
    int          m_idx [4];
    bit          m_busy, m_hn, m_hp, m_ack, m_err;

    color_regfile_param dut (
        .clk(clk), .rst(rst), .channel(channel), .address(address), .data(data),
        .valid(valid), .ack(ack), .err(err), .color_next(color_next),
        .color_prev(color_prev), .rgb(rgb), .preset_idx(preset_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rgb_of(input int i);
        return rgb[24*i +: 24];
    endfunction

    function automatic int idx_of(input int i);
        return int'(preset_idx[3*i +: 3]);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_idx[i] = i;
            m_rgb[i] = rom_m[i];
        end
        m_busy = 0; m_hn = 0; m_hp = 0; m_ack = 0; m_err = 0;
    endtask

    // advance the model by one clock from the currently driven inputs, then clock the DUT
    task automatic cycle();
        logic [23:0] nr [4];
        int ni [4];
        bit ok, ne, pe;
        int ch, sh;
        nr = m_rgb; ni = m_idx; ch = int'(channel);
        m_ack = 0; m_err = 0;
        if (rst) m_reset();
        else begin
            if (!m_busy && valid) begin
                ok = address >= 3 && address <= 10 && ch < 4;
                if (ok) begin
                    if (address == 9) begin
                        ni[ch] = int'(data) % 8;
                        nr[ch] = rom_m[ni[ch]];
                    end else if (address == 10) begin
                        nr[ch] = m_rgb[int'(data) % 4];
                        ni[ch] = m_idx[int'(data) % 4];
                    end else begin
                        sh = 20 - 4 * (int'(address) - 3);
                        nr[ch][sh +: 4] = data;
                    end
                end
                m_ack = ok; m_err = !ok; m_busy = 1;
            end else m_busy = 0;
            ne = color_next && !m_hn;
            pe = color_prev && !m_hp;
            if (ne != pe && ch < 4) begin
                ni[ch] = (m_idx[ch] + (ne ? 1 : 7)) % 8;
                nr[ch] = rom_m[ni[ch]];
            end
            m_hn = color_next; m_hp = color_prev;
            m_rgb = nr; m_idx = ni;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; channel = 0; address = 0; data = 0; valid = 0; color_next = 0; color_prev = 0;
        repeat (2) @(posedge clk);
        #1; rst = 0; m_reset();
        n_checks++; if (rgb !== 96'hFFFF00_0000FF_00FF00_FF0000) begin n_fail++; $display("FAIL reset_rgb: got %h expected %h", rgb, 96'hFFFF00_0000FF_00FF00_FF0000); end
        n_checks++; if (preset_idx !== 12'h688) begin n_fail++; $display("FAIL reset_idx: got %h expected %h", preset_idx, 12'h688); end
        n_checks++; if (ack !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b%b expected 00", ack, err); end
    endtask

    task automatic test_nibble();
        channel = 1; address = 3; data = 4'hA; valid = 1; cycle();
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL nibble_ack1: got %b expected 1", ack); end
        valid = 0; cycle();
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL nibble_ack_drop: got %b expected 0", ack); end
        address = 8; data = 4'h5; valid = 1; cycle();
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL nibble_ack2: got %b expected 1", ack); end
        valid = 0; cycle();
        n_checks++; if (rgb_of(1) !== 24'hA0FF05) begin n_fail++; $display("FAIL nibble_rgb1: got %h expected A0FF05", rgb_of(1)); end
        n_checks++; if (idx_of(1) != 1) begin n_fail++; $display("FAIL nibble_idx1: got %0d expected 1", idx_of(1)); end
    endtask

    task automatic test_valid_held();
        int pat [6] = '{0, 1, 0, 1, 0, 1};
        channel = 0; address = 4; data = 0; valid = 1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cycle();
            n_checks++; if (int'(ack) != pat[k]) begin n_fail++; $display("FAIL held_ack[%0d]: got %b expected %0d", k, ack, pat[k]); end
        end
        valid = 0; cycle();
        n_checks++; if (rgb_of(0) !== 24'hF00000) begin n_fail++; $display("FAIL held_rgb0: got %h expected F00000", rgb_of(0)); end
    endtask

    task automatic test_buttons();
        channel = 3; color_next = 1; cycle();
        n_checks++; if (idx_of(3) != 4 || rgb_of(3) !== 24'h00FFFF) begin n_fail++; $display("FAIL next1_ch3: got %0d/%h expected 4/00FFFF", idx_of(3), rgb_of(3)); end
        cycle(); cycle();
        n_checks++; if (idx_of(3) != 4) begin n_fail++; $display("FAIL next_held_ch3: got %0d expected 4", idx_of(3)); end
        color_next = 0; cycle();
        color_next = 1; cycle();
        color_next = 0; cycle();
        n_checks++; if (idx_of(3) != 5 || rgb_of(3) !== 24'hFF00FF) begin n_fail++; $display("FAIL next2_ch3: got %0d/%h expected 5/FF00FF", idx_of(3), rgb_of(3)); end
        channel = 0; color_prev = 1; cycle();
        color_prev = 0; cycle();
        n_checks++; if (idx_of(0) != 7 || rgb_of(0) !== 24'h000000) begin n_fail++; $display("FAIL prev_wrap_ch0: got %0d/%h expected 7/000000", idx_of(0), rgb_of(0)); end
    endtask

    task automatic test_preset_copy_err();
        channel = 2; address = 9; data = 6; valid = 1; cycle();
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL load_ack: got %b expected 1", ack); end
        valid = 0; cycle();
        n_checks++; if (idx_of(2) != 6 || rgb_of(2) !== 24'hFFFFFF) begin n_fail++; $display("FAIL load_ch2: got %0d/%h expected 6/FFFFFF", idx_of(2), rgb_of(2)); end
        channel = 0; address = 10; data = 2; valid = 1; cycle();
        valid = 0; cycle();
        n_checks++; if (idx_of(0) != 6 || rgb_of(0) !== 24'hFFFFFF) begin n_fail++; $display("FAIL copy_ch0: got %0d/%h expected 6/FFFFFF", idx_of(0), rgb_of(0)); end
        address = 11; data = 4'h3; valid = 1; cycle();
        n_checks++; if (err !== 1'b1 || ack !== 1'b0) begin n_fail++; $display("FAIL bad_addr_pulse: got err=%b ack=%b expected err=1 ack=0", err, ack); end
        n_checks++; if (rgb !== 96'hFF00FF_FFFFFF_A0FF05_FFFFFF || preset_idx !== 12'hB8E) begin n_fail++; $display("FAIL bad_addr_state: got %h/%h expected FF00FFFFFFFFA0FF05FFFFFF/B8E", rgb, preset_idx); end
        valid = 0; cycle();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL bad_addr_err_drop: got %b expected 0", err); end
    endtask

    task automatic test_simultaneous();
        channel = 1; color_next = 1; color_prev = 1; cycle();
        n_checks++; if (idx_of(1) != 1 || rgb_of(1) !== 24'hA0FF05) begin n_fail++; $display("FAIL both_buttons: got %0d/%h expected 1/A0FF05", idx_of(1), rgb_of(1)); end
        color_next = 0; color_prev = 0; cycle();
        color_next = 1; address = 3; data = 0; valid = 1; cycle();
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL btn_cmd_ack: got %b expected 1", ack); end
        n_checks++; if (idx_of(1) != 2 || rgb_of(1) !== 24'h0000FF) begin n_fail++; $display("FAIL btn_wins: got %0d/%h expected 2/0000FF", idx_of(1), rgb_of(1)); end
        color_next = 0; valid = 0; cycle();
    endtask

    task automatic test_random();
        logic [95:0] exp_rgb;
        logic [11:0] exp_idx;
        for (int n = 0; n < 400; n++) begin
            channel    = 2'($urandom_range(0, 3));
            address    = 4'($urandom_range(0, 15));
            data       = 4'($urandom);
            valid      = $urandom_range(0, 2) != 0;
            color_next = $urandom_range(0, 3) == 0;
            color_prev = $urandom_range(0, 3) == 0;
            cycle();
            for (int i = 0; i < 4; i++) begin
                exp_rgb[24*i +: 24] = m_rgb[i];
                exp_idx[3*i +: 3]   = 3'(m_idx[i]);
            end
            n_checks++; if (ack !== m_ack || err !== m_err) begin n_fail++; $display("FAIL rand_ack_err[%0d]: got %b%b expected %b%b", n, ack, err, m_ack, m_err); end
            n_checks++; if (rgb !== exp_rgb) begin n_fail++; $display("FAIL rand_rgb[%0d]: got %h expected %h", n, rgb, exp_rgb); end
            n_checks++; if (preset_idx !== exp_idx) begin n_fail++; $display("FAIL rand_idx[%0d]: got %h expected %h", n, preset_idx, exp_idx); end
        end
        valid = 0; color_next = 0; color_prev = 0; cycle();
    endtask

    task automatic test_reset_mid();
        channel = 0; address = 3; data = 4'hF; valid = 1; color_next = 1; color_prev = 0;
        rst = 1; #2; m_reset();
        n_checks++; if (rgb !== 96'hFFFF00_0000FF_00FF00_FF0000 || preset_idx !== 12'h688) begin n_fail++; $display("FAIL async_reset: got %h/%h expected reset values", rgb, preset_idx); end
        n_checks++; if (ack !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL async_reset_ack: got %b%b expected 00", ack, err); end
        cycle();
        rst = 0; valid = 0; cycle();
        n_checks++; if (idx_of(0) != 1 || rgb_of(0) !== 24'h00FF00) begin n_fail++; $display("FAIL held_after_reset: got %0d/%h expected 1/00FF00", idx_of(0), rgb_of(0)); end
    endtask

    initial begin
        test_reset();
        test_nibble();
        test_valid_held();
        test_buttons();
        test_preset_copy_err();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/color_regfile_param.md
Name: color_regfile_param

Overview:
- Parametrised colour register file for the VGA pipeline, holding one 24-bit RGB colour (R[23:16], G[15:8], B[7:0]) per drawing channel.
- Sits between the UART/command decoder, which issues nibble writes over a valid/ack handshake, and the pixel generator, which reads the rgb bus.
- Front-panel buttons step each channel forwards or backwards through a preset colour ROM.
- Adds over the previous generation: configurable channel and preset counts, reverse stepping, a direct preset-load command, a channel-to-channel copy command, an error pulse, and a preset-index readout.

Parameters:
- NUM_CH, 4, number of colour channels (1..2**CH_W).
- CH_W, 2, width of the channel select.
- NUM_PRESET, 8, preset ROM depth (2..2**PRE_W).
- PRE_W, 3, width of each preset index.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high.
- channel  in  CH_W  target channel for commands and button events.
- address  in  4  command code.
- data  in  4  command payload.
- valid  in  1  command request.
- ack  out  1  one-cycle command accept pulse.
- err  out  1  one-cycle reject pulse.
- color_next  in  1  level button, step preset forward (pre-debounced, synchronous).
- color_prev  in  1  level button, step preset backward.
- rgb  out  NUM_CH*24  channel i colour at [24i+23:24i].
- preset_idx  out  NUM_CH*PRE_W  channel i current preset index at [PRE_W*i+PRE_W-1:PRE_W*i].

Behaviour:
- Everything is registered on the rising edge of clk. Outputs come directly from flops.
- Preset ROM contents (constant), for index k mod 8:
  - 0 FF0000
  - 1 00FF00
  - 2 0000FF
  - 3 FFFF00
  - 4 00FFFF
  - 5 FF00FF
  - 6 FFFFFF
  - 7 000000
- Reset values:
  - rgb ch i = ROM[i mod NUM_PRESET]; preset_idx ch i = i mod NUM_PRESET.
  - ack = 0, err = 0.
  - Button history flops = 0; handshake state = IDLE.
- Handshake FSM has two states, IDLE and ACK.
  - IDLE with valid=1: the command is evaluated at this edge. If legal, it is applied, ack=1 next cycle, go to ACK. If illegal, err=1 next cycle, go to ACK.
  - ACK: ack and err return to 0. valid is ignored. Next state is IDLE.
  - If valid stays high, a command executes every 2 cycles and ack/err alternate 1,0,1,0. Latency from command edge to ack is 1 cycle.
- Command map (addr -> action on the selected channel ch):
  - 3: R[7:4] = data. 4: R[3:0]. 5: G[7:4]. 6: G[3:0]. 7: B[7:4]. 8: B[3:0].
  - 9: preset load. rgb = ROM[data[PRE_W-1:0]], preset_idx = data[PRE_W-1:0].
  - A: copy. rgb[ch] = rgb[data[CH_W-1:0]] as sampled before this edge; preset_idx[ch] is copied too.
  - Nibble writes (3..8) leave preset_idx unchanged.
- A command is illegal, producing err with no state change, when any of these holds:
  - address is outside 3..A;
  - channel >= NUM_CH;
  - addr 9 with data[PRE_W-1:0] >= NUM_PRESET;
  - addr A with source >= NUM_CH.
- Buttons:
  - Each button is registered once for history.
  - A rising edge (in=1, history=0) is an event. Holding a button produces exactly one event.
  - next: idx = (idx == NUM_PRESET-1) ? 0 : idx+1.
  - prev: idx = (idx == 0) ? NUM_PRESET-1 : idx-1.
  - In both cases rgb = ROM[new idx], and the change is visible 1 cycle after the edge.
  - A button event with channel >= NUM_CH is ignored. No err is raised for buttons.
- Simultaneous events:
  - next and prev rising on the same edge: no change, and both histories still update.
  - Button event and accepted command on the same channel and same edge: the button result wins for the whole rgb and the index; ack is still issued.
  - Button event and command on different channels: both apply.
- Reset asserted mid-handshake or mid-press: all state returns to reset values immediately. A button still held at deassertion counts as a rising edge on the first clock.

Test Plan:
- Reset with defaults -> rgb = {FFFF00,0000FF,00FF00,FF0000} (ch3..ch0), preset_idx = {3,2,1,0}, ack = 0, err = 0.
- ch1, addr 3 data A, then addr 8 data 5, valid pulsed -> ack exactly 1 cycle after each; rgb[1] = A0FF05.
- valid held high 6 cycles, addr 4, ch0 -> ack pattern 0,1,0,1,0,1; rgb[0] = F00000 when data = 0 for all.
- ch3 at idx 3: two color_next presses -> idx 4 then idx 5, rgb FF00FF. ch0: color_prev -> idx 7 (wrap), rgb 000000. A held button gives a single step.
- addr 9 data 6 on ch2 -> rgb[2] = FFFFFF, idx 6. addr A data 2 on ch0 -> rgb[0] = FFFFFF, idx 6. addr B -> err = 1 for 1 cycle, no ack, nothing changes.
- color_next and color_prev rising together on ch1 -> no change. color_next plus addr 3 data 0 on ch1 at the same edge -> rgb[1] = 0000FF, ack = 1.
